ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
Instruction fetch unit for the multi-cycle/pipelined CPU. It owns the PC and drives byte addresses into the combinational instruction memory. It captures the returned instruction words into a 2-entry fetch queue. It presents them to decode with a valid/ready handshake and accepts redirects (branch/jump/exception) that flush the queue.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset
IM_BASE, 32'h0000_3000, byte address of instruction memory word 0
IM_WORDS, 1024, instruction memory depth in 32-bit words

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
im_addr  output  32  byte address to instruction memory (= pc)
im_instr  input  32  instruction word returned combinationally for im_addr
redirect_valid  input  1  load redirect_pc this cycle, flush queue
redirect_pc  input  32  new fetch address
if_valid  output  1  head of queue holds an instruction
if_ready  input  1  decode accepts head this cycle
if_instr  output  32  head instruction
if_pc  output  32  head instruction address
if_pc4  output  32  if_pc + 4

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset); reset is fixed, not a parameter.
- Reset, asynchronous on reset low, state held while low:
  - pc = PC_RESET, count = 0.
  - if_valid = 0; if_instr, if_pc and if_pc4 read 0.
  - im_addr = PC_RESET.
- State: pc register, 2-entry circular queue of {pc, instr}, 1-bit rd_ptr, 1-bit wr_ptr, 2-bit count (0..2).
- im_addr = pc, combinational from the register. The instruction is sampled from im_instr in the same cycle.
- if_valid = (count != 0). if_instr and if_pc come from the entry at rd_ptr, registered outputs only (no im_instr→if_instr combinational path). When empty, they read 0.
- pop = if_valid & if_ready.
- push = !redirect_valid & ((count < 2) | pop).
- Normal edge:
  - On push: write {pc, im_instr} at wr_ptr, wr_ptr++, pc <= pc + 4.
  - On pop: rd_ptr++.
  - count += push - pop.
- Full (count = 2) and no pop: no push, pc holds, queue unchanged.
- Full with pop: simultaneous push and pop, count stays 2.
- Empty with if_ready = 1: no pop (pop requires valid). Push still occurs.
- redirect_valid has priority over everything:
  - pc <= {redirect_pc[31:2], 2'b00}, count <= 0, rd_ptr = wr_ptr = 0.
  - No push that cycle. A simultaneous pop is discarded along with the flush.
  - Next cycle if_valid = 0, and im_addr = redirect target.
  - The first redirected instruction becomes valid after one more edge: 2 edges from the redirect edge to if_valid.
- Latency after reset release: first instruction (pc PC_RESET) is valid after the 1st rising edge. Steady-state throughput is 1 instruction/cycle with if_ready held high.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset asserted mid-operation clears the queue immediately. Queued instructions are lost.

Optional Feature:
Macro IFU_ADDR_CHECK_EN.
- Defined:
  - Adds output if_exc (1 bit, reset 0), stored per queue entry.
  - An entry's exc flag is set when its pc[1:0] != 0 or pc lies outside [IM_BASE, IM_BASE + 4*IM_WORDS).
  - A flagged entry stores instr = 32'h0000_0000 (nop) instead of im_instr.
  - redirect_pc is loaded unmodified; low bits are not cleared.
  - Fetch continues sequentially; flushing is decode's responsibility via redirect.
- Undefined: no if_exc port, no range check, and redirect_pc[1:0] are forced to 0.

Test Plan:
- Reset release, IM returns addr-derived words, if_ready = 1 → if_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles, with if_pc4 = if_pc + 4.
- if_ready = 0 for 5 cycles → count saturates at 2, pc holds at 0x3008, and im_addr stays 0x3008. Then if_ready = 1 → 0x3000, 0x3004, 0x3008 delivered in order, with no duplicate or skip.
- redirect_valid with redirect_pc = 0x3100 while full and if_ready = 1 → next cycle if_valid = 0; following cycle if_pc = 0x3100. No stale 0x300x entry appears.
- redirect_pc = 0x3102, macro undefined → fetch at 0x3100. Macro defined → if_exc = 1 and if_instr = 0 for 0x3102.
- redirect_pc = 0xFFFF_FFFC → if_pc 0xFFFF_FFFC, then 0x0000_0000 (wrap); with the macro defined, both are flagged out-of-range.
- Assert reset for 1 cycle mid-stream with count = 2 → if_valid drops immediately. After release, the first if_pc = 0x3000.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: owns the PC, drives the instruction memory and buffers fetched words in a 2-entry queue.
// Optional fetch address checking (if_exc output) is enabled with `define IFU_ADDR_CHECK_EN.
module ifu_fetch_queue #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
`ifdef IFU_ADDR_CHECK_EN
  ,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
`ifdef IFU_ADDR_CHECK_EN
  ,
  output logic        if_exc
`endif
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  logic [31:0]   pc_q;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          pop_c;
  logic          push_c;
  logic [31:0]   redirect_target_c;
  logic [31:0]   fetch_instr_c;

`ifdef IFU_ADDR_CHECK_EN
  localparam logic [32:0] IM_LIMIT = 33'(IM_BASE) + 33'(IM_WORDS) * 33'd4;

  logic q_exc [DEPTH];
  logic fetch_exc_c;

  // Misaligned or out-of-memory fetches are flagged and replaced by a nop.
  always_comb begin
    fetch_exc_c = (pc_q[1:0] != 2'b00) ||
                  (pc_q < IM_BASE) ||
                  (33'(pc_q) >= IM_LIMIT);
    fetch_instr_c = fetch_exc_c ? 32'h0000_0000 : im_instr;
    redirect_target_c = redirect_pc;
  end
`else
  always_comb begin
    fetch_instr_c = im_instr;
    redirect_target_c = redirect_pc & 32'hFFFF_FFFC;
  end
`endif

  // Pop only a valid head; a redirect suppresses the fetch of this cycle.
  always_comb begin
    pop_c  = if_valid & if_ready;
    push_c = !redirect_valid & ((count_q != CW'(DEPTH)) | pop_c);
  end

  // PC, queue storage and pointers; a redirect flushes everything including a concurrent pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= PC_RESET;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
`ifdef IFU_ADDR_CHECK_EN
        q_exc[i]   <= 1'b0;
`endif
      end
    end else if (redirect_valid) begin
      pc_q     <= redirect_target_c;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        q_pc[wr_ptr_q]    <= pc_q;
        q_instr[wr_ptr_q] <= fetch_instr_c;
`ifdef IFU_ADDR_CHECK_EN
        q_exc[wr_ptr_q]   <= fetch_exc_c;
`endif
        wr_ptr_q <= ~wr_ptr_q;
        pc_q     <= pc_q + 32'd4;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // Head view comes straight from queue registers; forced to zero when empty.
  always_comb begin
    im_addr  = pc_q;
    if_valid = (count_q != '0);
    if_pc    = if_valid ? q_pc[rd_ptr_q] : 32'h0000_0000;
    if_instr = if_valid ? q_instr[rd_ptr_q] : 32'h0000_0000;
    if_pc4   = if_valid ? (q_pc[rd_ptr_q] + 32'd4) : 32'h0000_0000;
`ifdef IFU_ADDR_CHECK_EN
    if_exc   = if_valid ? q_exc[rd_ptr_q] : 1'b0;
`endif
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Scoreboard bench for ifu_fetch_queue: directed phases push expected fetches, a negedge monitor checks accepted heads.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
`ifdef IFU_ADDR_CHECK_EN
  logic        if_exc;
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Instruction memory model: address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[31:16], a[15:0] ^ 16'hC0DE};
  endfunction

  assign im_instr = mem_word(im_addr);

  ifu_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4)
`ifdef IFU_ADDR_CHECK_EN
    ,
    .if_exc         (if_exc)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] pc, input logic exc);
    exp_t e;
    e.pc    = pc;
    e.exc   = exc;
    e.instr = exc ? 32'h0000_0000 : mem_word(pc);
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted head must match the oldest expected fetch.
  always @(negedge clk) begin
    if (reset && if_valid && if_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got pc %h, expected no delivery", if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_pc", if_pc, mon_e.pc);
        check("pop_pc4", if_pc4, mon_e.pc + 32'd4);
        check("pop_instr", if_instr, mon_e.instr);
`ifdef IFU_ADDR_CHECK_EN
        check("pop_exc", 32'(if_exc), 32'(mon_e.exc));
`endif
      end
    end
  end

  initial begin
    reset          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_pc4", if_pc4, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_im_addr", im_addr, 32'h0000_3000);

    // Stall with decode not ready: queue fills and pc holds.
    reset = 1'b1;
    repeat (5) tick();
    check("full_im_addr", im_addr, 32'h0000_3008);
    check("full_valid", 32'(if_valid), 32'd1);
    check("full_head_pc", if_pc, 32'h0000_3000);
    check("full_head_pc4", if_pc4, 32'h0000_3004);

    // Drain at one per cycle, in order.
    expect_fetch(32'h0000_3000, 1'b0);
    expect_fetch(32'h0000_3004, 1'b0);
    expect_fetch(32'h0000_3008, 1'b0);
    expect_fetch(32'h0000_300C, 1'b0);
    if_ready = 1'b1;
    repeat (4) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_head_pc", if_pc, 32'h0000_3010);

    // Redirect while full with a concurrent ready.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid_drop", 32'(if_valid), 32'd0);
    check("redir_im_addr", im_addr, 32'h0000_3100);
    expect_fetch(32'h0000_3100, 1'b0);
    expect_fetch(32'h0000_3104, 1'b0);
    expect_fetch(32'h0000_3108, 1'b0);
    tick();
    check("redir_first_valid", 32'(if_valid), 32'd1);
    check("redir_first_pc", if_pc, 32'h0000_3100);
    repeat (3) tick();
    check("redir_left", 32'(exp_q.size()), 32'd0);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3102;
    tick();
    redirect_valid = 1'b0;
    if (CHK) begin
      check("misalign_im_addr", im_addr, 32'h0000_3102);
      expect_fetch(32'h0000_3102, 1'b1);
      expect_fetch(32'h0000_3106, 1'b1);
    end else begin
      check("misalign_im_addr", im_addr, 32'h0000_3100);
      expect_fetch(32'h0000_3100, 1'b0);
      expect_fetch(32'h0000_3104, 1'b0);
    end
    repeat (3) tick();
    check("misalign_left", 32'(exp_q.size()), 32'd0);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_im_addr", im_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC, CHK);
    expect_fetch(32'h0000_0000, CHK);
    repeat (3) tick();
    if_ready = 1'b0;
    check("wrap_left", 32'(exp_q.size()), 32'd0);
    check("wrap_im_addr_after", im_addr, 32'h0000_0008);

    // Reset mid-stream with a full queue.
    repeat (3) tick();
    check("pre_rst_valid", 32'(if_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_pc", if_pc, 32'h0);
    check("mid_rst_im_addr", im_addr, 32'h0000_3000);
    tick();
    reset = 1'b1;
    expect_fetch(32'h0000_3000, 1'b0);
    if_ready = 1'b1;
    tick();
    check("post_rst_pc", if_pc, 32'h0000_3000);
    tick();
    if_ready = 1'b0;
    tick();
    check("final_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
